// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage: NRD registered read ports with
// write-first byte-merged bypass, NWR byte-enabled write ports, and a debug tap.
module regfile_mp #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NRD     = 2,
   parameter int unsigned NWR     = 1,
   parameter bit          ZERO_R0 = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NRD-1:0]           rd_en,
   input  logic [NRD*ADDR_W-1:0]    raddr,
   output logic [NRD*DATA_W-1:0]    dout,
   input  logic [NWR-1:0]           we,
   input  logic [NWR*(DATA_W/8)-1:0] be,
   input  logic [NWR*ADDR_W-1:0]    waddr,
   input  logic [NWR*DATA_W-1:0]    din,
   input  logic [ADDR_W-1:0]        dbg_addr,
   output logic [DATA_W-1:0]        dbg_dout
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_val_c [NRD];

   // Write-first read value: stored entry overlaid per byte by every active write,
   // higher-numbered ports applied last so they win on shared bytes.
   always_comb begin
      for (int unsigned i = 0; i < NRD; i++) begin
         rd_val_c[i] = mem[raddr[i*ADDR_W +: ADDR_W]];
         for (int unsigned j = 0; j < NWR; j++) begin
            for (int unsigned b = 0; b < NB; b++) begin
               if (we[j] && be[j*NB + b] &&
                   (waddr[j*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])) begin
                  rd_val_c[i][b*8 +: 8] = din[j*DATA_W + b*8 +: 8];
               end
            end
         end
         if (ZERO_R0 && (raddr[i*ADDR_W +: ADDR_W] == '0)) begin
            rd_val_c[i] = '0;
         end
      end
   end

   // Storage update; same loop order as the bypass so collisions resolve identically.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned e = 0; e < DEPTH; e++) begin
            mem[e] <= '0;
         end
      end else begin
         for (int unsigned e = 0; e < DEPTH; e++) begin
            if (!(ZERO_R0 && (e == 0))) begin
               for (int unsigned j = 0; j < NWR; j++) begin
                  for (int unsigned b = 0; b < NB; b++) begin
                     if (we[j] && be[j*NB + b] &&
                         (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(e))) begin
                        mem[e][b*8 +: 8] <= din[j*DATA_W + b*8 +: 8];
                     end
                  end
               end
            end
         end
      end
   end

   // Registered read ports; a disabled port holds its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else begin
         for (int unsigned i = 0; i < NRD; i++) begin
            if (rd_en[i]) begin
               dout[i*DATA_W +: DATA_W] <= rd_val_c[i];
            end
         end
      end
   end

   assign dbg_dout = (ZERO_R0 && (dbg_addr == '0)) ? '0 : mem[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (ZERO_R0=1 and ZERO_R0=0, both NWR=2)
// share stimulus; a vector table covers bypass, byte enables, collisions and hold.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic [1:0]  rd_en;
   logic [9:0]  raddr;
   logic [1:0]  we;
   logic [7:0]  be;
   logic [9:0]  waddr;
   logic [63:0] din;
   logic [4:0]  dbg_addr;
   logic [63:0] dout_a, dout_b;
   logic [31:0] dbg_a, dbg_b;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_R0(1'b1)) dut_a (
      .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .dout(dout_a),
      .we(we), .be(be), .waddr(waddr), .din(din),
      .dbg_addr(dbg_addr), .dbg_dout(dbg_a));

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_R0(1'b0)) dut_b (
      .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .dout(dout_b),
      .we(we), .be(be), .waddr(waddr), .din(din),
      .dbg_addr(dbg_addr), .dbg_dout(dbg_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  we;
      logic [7:0]  be;
      logic [9:0]  waddr;
      logic [63:0] din;
      logic [1:0]  rd_en;
      logic [9:0]  raddr;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic [1:0] w, input logic [3:0] be1, input logic [3:0] be0,
                               input logic [4:0] wa1, input logic [4:0] wa0,
                               input logic [31:0] d1, input logic [31:0] d0,
                               input logic [1:0] r, input logic [4:0] ra1, input logic [4:0] ra0,
                               input logic [31:0] ea1, input logic [31:0] ea0,
                               input logic [31:0] eb1, input logic [31:0] eb0);
      vec_t v;
      v.we = w;       v.be = {be1, be0};   v.waddr = {wa1, wa0}; v.din = {d1, d0};
      v.rd_en = r;    v.raddr = {ra1, ra0};
      v.exp_a = {ea1, ea0};                v.exp_b = {eb1, eb0};
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic idle();
      we = '0; be = '0; waddr = '0; din = '0; rd_en = '0; raddr = '0;
   endtask

   initial begin
      //            we    be1   be0   wa1 wa0 d1            d0            rd    ra1 ra0 ea1           ea0           eb1           eb0
      vecs[0]  = mk(2'b01, 4'h0, 4'hF, 0,  1, 32'h0,        32'h11111111, 2'b11, 2,  1, 32'h0,        32'h11111111, 32'h0,        32'h11111111);
      vecs[1]  = mk(2'b11, 4'hF, 4'hF, 3,  2, 32'h33333333, 32'h22222222, 2'b11, 1,  2, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222);
      vecs[2]  = mk(2'b00, 4'h0, 4'h0, 0,  0, 32'h0,        32'h0,        2'b11, 3,  3, 32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333);
      vecs[3]  = mk(2'b01, 4'h0, 4'hF, 0,  5, 32'h0,        32'hDEADBEEF, 2'b11, 0,  5, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF);
      vecs[4]  = mk(2'b01, 4'h0, 4'hF, 0,  7, 32'h0,        32'h11223344, 2'b00, 7,  7, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF);
      vecs[5]  = mk(2'b01, 4'h0, 4'h5, 0,  7, 32'h0,        32'hAABBCCDD, 2'b01, 0,  7, 32'h0,        32'h11BB33DD, 32'h0,        32'h11BB33DD);
      vecs[6]  = mk(2'b01, 4'h0, 4'hF, 0,  0, 32'h0,        32'hFFFFFFFF, 2'b11, 7,  0, 32'h11BB33DD, 32'h0,        32'h11BB33DD, 32'hFFFFFFFF);
      vecs[7]  = mk(2'b11, 4'h2, 4'hF, 9,  9, 32'h0000BB00, 32'h000000AA, 2'b11, 0,  9, 32'h0,        32'h0000BBAA, 32'hFFFFFFFF, 32'h0000BBAA);
      vecs[8]  = mk(2'b11, 4'h6, 4'hC, 10, 10, 32'hAAAAAAAA, 32'h12345678, 2'b11, 10, 10, 32'h12AAAA00, 32'h12AAAA00, 32'h12AAAA00, 32'h12AAAA00);
      vecs[9]  = mk(2'b01, 4'h0, 4'hF, 0,  9, 32'h0,        32'h55555555, 2'b00, 9,  9, 32'h12AAAA00, 32'h12AAAA00, 32'h12AAAA00, 32'h12AAAA00);
      vecs[10] = mk(2'b00, 4'h0, 4'h0, 0,  0, 32'h0,        32'h0,        2'b11, 5,  9, 32'hDEADBEEF, 32'h55555555, 32'hDEADBEEF, 32'h55555555);

      // Initial reset
      idle();
      dbg_addr = 5'd31;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_dout_a", dout_a, 64'h0);
      check("reset_dout_b", dout_b, 64'h0);
      check("reset_dbg31", {32'h0, dbg_a}, 64'h0);
      rst = 1'b0;

      // Table-driven vectors: apply at negedge, compare one edge later
      for (int k = 0; k < NV; k++) begin
         we = vecs[k].we; be = vecs[k].be; waddr = vecs[k].waddr; din = vecs[k].din;
         rd_en = vecs[k].rd_en; raddr = vecs[k].raddr;
         @(negedge clk);
         check($sformatf("vec%0d_dout_zr", k), dout_a, vecs[k].exp_a);
         check($sformatf("vec%0d_dout_nz", k), dout_b, vecs[k].exp_b);
      end

      // Debug tap: zero register masking and stored contents
      idle();
      dbg_addr = 5'd0;  #1;
      check("dbg0_zr", {32'h0, dbg_a}, 64'h0);
      check("dbg0_nz", {32'h0, dbg_b}, 64'hFFFFFFFF);
      dbg_addr = 5'd7;  #1;
      check("dbg7", {32'h0, dbg_a}, 64'h11BB33DD);

      // Debug tap sees a write only after its edge
      @(negedge clk);
      we = 2'b01; be = 8'h0F; waddr = {5'd0, 5'd12}; din = {32'h0, 32'hCAFEF00D};
      dbg_addr = 5'd12; #1;
      check("dbg12_pre_edge", {32'h0, dbg_a}, 64'h0);
      @(negedge clk);
      check("dbg12_post_edge", {32'h0, dbg_a}, 64'hCAFEF00D);

      // Reset racing a write and read: reset wins everything
      idle();
      rst = 1'b1;
      we = 2'b01; be = 8'h0F; waddr = {5'd0, 5'd4}; din = {32'h0, 32'h44444444};
      rd_en = 2'b11; raddr = {5'd4, 5'd4};
      @(negedge clk);
      check("rst_race_dout_zr", dout_a, 64'h0);
      check("rst_race_dout_nz", dout_b, 64'h0);
      rst = 1'b0;
      idle();
      begin
         logic [4:0] dbg_list [5];
         dbg_list = '{5'd1, 5'd2, 5'd3, 5'd31, 5'd4};
         for (int k = 0; k < 5; k++) begin
            dbg_addr = dbg_list[k]; #1;
            check($sformatf("rst_dbg%0d", dbg_list[k]), {32'h0, dbg_a}, 64'h0);
         end
      end

      // First edge after reset performs normal write plus bypassed read
      @(negedge clk);
      we = 2'b01; be = 8'h0F; waddr = {5'd0, 5'd4}; din = {32'h0, 32'h44444444};
      rd_en = 2'b11; raddr = {5'd4, 5'd4};
      @(negedge clk);
      check("post_rst_write_read", dout_a, 64'h44444444_44444444);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS pipeline datapath: the next generation of the single-write, dual-read register bank. Provides NRD read ports and NWR write ports, per-byte write enables, and a registered read path with same-cycle write-through bypass. Adds synchronous reset and a combinational debug tap. Sits in the decode stage; writeback drives the write ports.

## Interface

- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; depth = 2**ADDR_W entries.
- NRD, 2: number of read ports, 1..4.
- NWR, 1: number of write ports, 1..2.
- ZERO_R0, 1: when 1, entry 0 is hardwired to zero.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  NRD  per-port read enable.
- raddr  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- dout  out  NRD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W].
- we  in  NWR  per-port write enable.
- be  in  NWR*(DATA_W/8)  per-port byte enables; byte b of port j at bit j*(DATA_W/8)+b.
- waddr  in  NWR*ADDR_W  write addresses.
- din  in  NWR*DATA_W  write data.
- dbg_addr  in  ADDR_W  debug tap address.
- dbg_dout  out  DATA_W  combinational array contents at dbg_addr; no bypass.

## Operation

- Storage: 2**ADDR_W x DATA_W flops.
- Reset: on posedge with rst=1, every entry := 0 and every dout := 0. Writes and reads in the same cycle are discarded.
- Write: on posedge with rst=0, for each port j with we[j]=1, each byte b with be[j][b]=1 is loaded from din[j]. Unselected bytes hold their value.
- Writes to entry 0 are ignored when ZERO_R0=1. When ZERO_R0=0, entry 0 is ordinary storage.
- Write collision (NWR=2, same waddr, both we): resolved per byte. Port 1 wins on bytes both ports enable. Bytes enabled by only one port take that port's data.
- Read: on posedge with rst=0, for each port i with rd_en[i]=1, dout[i] := value of entry raddr[i] as it stands after this edge's writes (write-first). This is bypass merged per byte over all active write ports, with the same collision priority as the write path.
- Read of entry 0 returns 0 when ZERO_R0=1, regardless of bypass.
- rd_en[i]=0: dout[i] holds its previous value.
- Reads never modify storage. Multiple read ports may share one address.
- dbg_dout: pure combinational view of storage. It reflects a write only after the write's clock edge. dbg_addr=0 with ZERO_R0=1 returns 0.

## Timing

- Read latency: 1 cycle. raddr/rd_en are sampled at edge N; dout is valid after edge N and stable until the next enabled edge.
- Write latency: 1 cycle. Data presented at edge N is in storage after edge N.
- Read and write of the same address at the same edge: dout shows the new (bypassed, byte-merged) data.
- Read of a register written at edge N-1 and read at edge N: dout shows the stored new value. No bubble is needed.
- Reset asserted mid-stream: the first edge with rst=1 clears everything. The first edge with rst=0 performs normal writes and reads.
- No combinational path from inputs to dout. dbg_addr to dbg_dout is combinational only.

## Test plan

- Reset: preload entries 1..3 with nonzero values, assert rst for 1 cycle. Then dout=0 on all ports, and dbg_dout=0 for addresses 1, 2, 3 and 31.
- Write-through bypass: we=1, waddr=5, din=0xDEADBEEF, be=4'hF, with raddr0=5 and rd_en0=1 at the same edge. After that edge, dout0=0xDEADBEEF.
- Byte enables: entry 7=0x11223344, then write din=0xAABBCCDD with be=4'b0101. Storage=0x11BB33DD; a same-edge read of 7 also returns 0x11BB33DD.
- Zero register: write 0xFFFFFFFF to address 0 with ZERO_R0=1. A read of 0 returns 0 and dbg_dout at address 0 is 0. Rerun with ZERO_R0=0: the read returns 0xFFFFFFFF.
- Dual-write collision (NWR=2): port0 writes 0x000000AA to 9 with be=4'hF, and port1 writes 0x0000BB00 to 9 with be=4'b0010 at the same edge. Entry 9=0x0000BBAA, and a same-edge read returns 0x0000BBAA.
- Read hold and reset race: rd_en0=0 while entry raddr0 changes, so dout0 keeps its old value. Assert rst together with we=1 to address 4: entry 4=0 afterwards.
